lockin_demod_cycle: RTL and testbench

Dual-phase lock-in demodulator that consumes one coherently averaged signal cycle (M samples) from the coherent averaging stage. Each sample is multiplied by its in-phase (cos) and quadrature (sin) reference, and both products are accumulated over the cycle. The block presents the 64-bit X/Y sums once per run, then holds them for the downstream readout logic.

---
 rtl/lockin_demod_cycle.sv | 158 +++++++++++++++
 tb/tb_lockin_demod_cycle.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lockin_demod_cycle.sv
// rtl/lockin_demod_cycle.sv - dual-phase lock-in demodulator over one averaged signal cycle
//
// Accumulates data*cos and data*sin over M samples of one averaged cycle,
// then presents the 64-bit sums once and holds them until reset.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   enable                  arms a run (sampled in IDLE only)
//   ptos_x_ciclo[15:0]      M, points per cycle, latched when a run starts
//   ref_wr_en/addr/sin/cos  reference table write port (IDLE only)
//   data_in_valid, data_in  signed sample stream, no backpressure
//   busy                    high while accumulating or draining
//   cfg_error               sticky: arming attempted with M=0 or M>LUT_DEPTH
//   result_valid            single-cycle pulse when results are loaded
//   result_x, result_y      signed sums of data*cos and data*sin
module lockin_demod_cycle #(
  parameter int LUT_DEPTH = 2048,
  parameter int REF_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [15:0]             ptos_x_ciclo,
  input  logic                    ref_wr_en,
  input  logic [10:0]             ref_wr_addr,
  input  logic signed [REF_W-1:0] ref_wr_sin,
  input  logic signed [REF_W-1:0] ref_wr_cos,
  input  logic                    data_in_valid,
  input  logic signed [31:0]      data_in,
  output logic                    busy,
  output logic                    cfg_error,
  output logic                    result_valid,
  output logic signed [63:0]      result_x,
  output logic signed [63:0]      result_y
);

  localparam int PW = 32 + REF_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0] m_lat;
  logic [10:0] idx;
  logic [1:0]  drain_cnt;

  logic signed [REF_W-1:0] cos_mem [LUT_DEPTH];
  logic signed [REF_W-1:0] sin_mem [LUT_DEPTH];

  logic                    s1_v;
  logic signed [31:0]      s1_data;
  logic signed [REF_W-1:0] s1_cos;
  logic signed [REF_W-1:0] s1_sin;
  logic                    s2_v;
  logic signed [PW-1:0]    s2_px;
  logic signed [PW-1:0]    s2_py;
  logic signed [63:0]      acc_x;
  logic signed [63:0]      acc_y;

  logic m_bad;
  logic start;
  logic accept;
  logic last_beat;
  logic drain_end;

  assign m_bad     = (ptos_x_ciclo == 16'd0) || ({16'd0, ptos_x_ciclo} > 32'(LUT_DEPTH));
  assign start     = (state == IDLE) && enable && !m_bad;
  assign accept    = (state == ACCUM) && data_in_valid;
  assign last_beat = accept && ({5'd0, idx} == (m_lat - 16'd1));
  // Three drain cycles: the last beat needs S1, S2 and the accumulate before
  // the sums can be copied to the result registers.
  assign drain_end = (state == DRAIN) && (drain_cnt == 2'd2);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = ACCUM;
      ACCUM:   if (last_beat) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    if (state == ACCUM || state == DRAIN) busy = 1'b1;
  end

  // Reference table and S1 operand capture. No reset here so the table
  // contents survive reset and the read maps onto synchronous-read RAM.
  always_ff @(posedge clk) begin
    if (ref_wr_en && state == IDLE) begin
      cos_mem[ref_wr_addr] <= ref_wr_cos;
      sin_mem[ref_wr_addr] <= ref_wr_sin;
    end
    s1_cos  <= cos_mem[idx];
    s1_sin  <= sin_mem[idx];
    s1_data <= data_in;
    s2_px   <= s1_data * s1_cos;
    s2_py   <= s1_data * s1_sin;
  end

  // Control counters, valid pipeline, accumulators and results
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_lat        <= '0;
      idx          <= '0;
      drain_cnt    <= '0;
      s1_v         <= 1'b0;
      s2_v         <= 1'b0;
      acc_x        <= '0;
      acc_y        <= '0;
      result_x     <= '0;
      result_y     <= '0;
      result_valid <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      s1_v         <= accept;
      s2_v         <= s1_v;
      result_valid <= 1'b0;

      if (state == IDLE && enable && m_bad) cfg_error <= 1'b1;

      if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
      else                drain_cnt <= '0;

      if (start) begin
        idx   <= '0;
        m_lat <= ptos_x_ciclo;
        acc_x <= '0;
        acc_y <= '0;
      end else begin
        // Hold idx on the final beat so it never wraps when M = LUT_DEPTH.
        if (accept && !last_beat) idx <= idx + 11'd1;
        if (s2_v) begin
          acc_x <= acc_x + {{(64-PW){s2_px[PW-1]}}, s2_px};
          acc_y <= acc_y + {{(64-PW){s2_py[PW-1]}}, s2_py};
        end
      end

      if (drain_end) begin
        result_x     <= acc_x;
        result_y     <= acc_y;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lockin_demod_cycle.sv
// tb/tb_lockin_demod_cycle.sv - directed self-checking bench for lockin_demod_cycle
module tb_lockin_demod_cycle;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic [15:0]        ptos_x_ciclo;
  logic               ref_wr_en;
  logic [10:0]        ref_wr_addr;
  logic signed [15:0] ref_wr_sin;
  logic signed [15:0] ref_wr_cos;
  logic               data_in_valid;
  logic signed [31:0] data_in;
  logic               busy;
  logic               cfg_error;
  logic               result_valid;
  logic signed [63:0] result_x;
  logic signed [63:0] result_y;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int exp_pulses = 0;

  lockin_demod_cycle #(.LUT_DEPTH(2048), .REF_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ptos_x_ciclo(ptos_x_ciclo),
    .ref_wr_en(ref_wr_en), .ref_wr_addr(ref_wr_addr), .ref_wr_sin(ref_wr_sin),
    .ref_wr_cos(ref_wr_cos), .data_in_valid(data_in_valid), .data_in(data_in),
    .busy(busy), .cfg_error(cfg_error), .result_valid(result_valid),
    .result_x(result_x), .result_y(result_y)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag,
             $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wr(input int a, input int c, input int s);
    ref_wr_en   = 1'b1;
    ref_wr_addr = 11'(a);
    ref_wr_cos  = 16'(c);
    ref_wr_sin  = 16'(s);
    step();
    ref_wr_en   = 1'b0;
  endtask

  task automatic beat(input logic signed [31:0] d);
    data_in_valid = 1'b1;
    data_in       = d;
    step();
    data_in_valid = 1'b0;
  endtask

  task automatic arm(input int m);
    ptos_x_ciclo = 16'(m);
    enable       = 1'b1;
    step();
    enable       = 1'b0;
  endtask

  task automatic wait_rv(input string tag, input int exp_k);
    int k = 0;
    while (result_valid !== 1'b1 && k < 12) begin
      step();
      k++;
    end
    chk(tag, 64'(k), 64'(exp_k));
  endtask

  task automatic run_basic(input string tag);
    arm(4);
    ptos_x_ciclo = 16'd1;
    chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
    beat(100);
    ref_wr_en = 1'b1; ref_wr_addr = 11'd3; ref_wr_cos = 16'sd12345; ref_wr_sin = 16'sd12345;
    beat(0);
    ref_wr_en = 1'b0;
    beat(-100);
    beat(0);
    chk({tag, "_rv_t1"}, 64'(result_valid), 64'd0);
    step();
    step();
    chk({tag, "_rv_t3"}, 64'(result_valid), 64'd0);
    chk({tag, "_busy_t3"}, 64'(busy), 64'd1);
    step();
    exp_pulses++;
    chk({tag, "_rv_t4"}, 64'(result_valid), 64'd1);
    chk({tag, "_busy_t4"}, 64'(busy), 64'd0);
    chk({tag, "_x"}, result_x, 64'sd3276800);
    chk({tag, "_y"}, result_y, 64'sd0);
    step();
    chk({tag, "_rv_t5"}, 64'(result_valid), 64'd0);
  endtask

  initial begin
    longint exp_y;
    reset_n = 1'b0; enable = 1'b0; ptos_x_ciclo = 16'd0; ref_wr_en = 1'b0;
    ref_wr_addr = '0; ref_wr_sin = '0; ref_wr_cos = '0;
    data_in_valid = 1'b0; data_in = '0;

    do_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cfg_error", 64'(cfg_error), 64'd0);
    chk("rst_rv", 64'(result_valid), 64'd0);
    chk("rst_x", result_x, 64'd0);
    chk("rst_y", result_y, 64'd0);

    wr(0, 16384, 0);
    wr(1, 0, 16384);
    wr(2, -16384, 0);
    wr(3, 0, -16384);

    // Invalid M
    ptos_x_ciclo = 16'd0; enable = 1'b1;
    step();
    chk("badm0_cfg_error", 64'(cfg_error), 64'd1);
    chk("badm0_busy", 64'(busy), 64'd0);
    ptos_x_ciclo = 16'd4096;
    step();
    step();
    chk("badm4096_busy", 64'(busy), 64'd0);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("badm_no_pulse", 64'(pulses), 64'(exp_pulses));
    chk("badm_cfg_sticky", 64'(cfg_error), 64'd1);
    do_reset();
    chk("badm_cfg_cleared", 64'(cfg_error), 64'd0);

    run_basic("basic");

    // Trailing beats after DONE
    for (int i = 0; i < 8; i++) beat(7777);
    for (int i = 0; i < 6; i++) step();
    chk("trail_pulses", 64'(pulses), 64'(exp_pulses));
    chk("trail_x", result_x, 64'sd3276800);
    chk("trail_y", result_y, 64'sd0);
    chk("trail_busy", 64'(busy), 64'd0);

    // Gapped input; also detects a reference write leaking in during ACCUM
    do_reset();
    arm(4);
    beat(0);
    step();
    beat(50);
    step(); step();
    beat(0);
    step(); step(); step();
    beat(-50);
    wait_rv("gap_latency", 3);
    exp_pulses++;
    chk("gap_x", result_x, 64'sd0);
    chk("gap_y", result_y, 64'sd1638400);

    // Reset mid-run with a beat coincident with reset
    do_reset();
    chk("rst2_y", result_y, 64'd0);
    arm(4);
    beat(100);
    beat(0);
    reset_n = 1'b0; data_in_valid = 1'b1; data_in = 32'sd100;
    step();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rv", 64'(result_valid), 64'd0);
    reset_n = 1'b1; data_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("midrst_no_pulse", 64'(pulses), 64'(exp_pulses));
    chk("midrst_busy_idle", 64'(busy), 64'd0);
    chk("midrst_x", result_x, 64'd0);
    run_basic("rerun");

    // M = 1
    do_reset();
    arm(1);
    beat(3);
    wait_rv("m1_latency", 3);
    exp_pulses++;
    chk("m1_x", result_x, 64'sd49152);
    chk("m1_y", result_y, 64'sd0);

    // Extremes, M = LUT_DEPTH
    do_reset();
    for (int i = 0; i < 2048; i++) wr(i, -32768, 32767);
    arm(2048);
    for (int i = 0; i < 2048; i++) beat(32'sh8000_0000);
    wait_rv("ext_latency", 3);
    exp_pulses++;
    exp_y = -(longint'(32767) <<< 42);
    chk("ext_x", result_x, 64'h0200_0000_0000_0000);
    chk("ext_y", result_y, 64'(exp_y));
    step();
    chk("total_pulses", 64'(pulses), 64'(exp_pulses));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
